// File: rtl/ssd_pkg.sv
// Shared seven-segment glyph table and segment bit order.
// All glyphs are active-low: a 0 bit lights the segment.
package ssd_pkg;

    // Physical pin order on the segment bus, MSB first.
    typedef struct packed {
        logic a;
        logic b;
        logic c;
        logic d;
        logic e;
        logic f;
        logic g;
        logic dp;
    } seg_bits_t;

    typedef logic [6:0] seg7_t;

    localparam seg7_t GLYPH_0     = 7'b0000001;
    localparam seg7_t GLYPH_1     = 7'b1001111;
    localparam seg7_t GLYPH_2     = 7'b0010010;
    localparam seg7_t GLYPH_3     = 7'b0000110;
    localparam seg7_t GLYPH_4     = 7'b1001100;
    localparam seg7_t GLYPH_5     = 7'b0100100;
    localparam seg7_t GLYPH_6     = 7'b0100000;
    localparam seg7_t GLYPH_7     = 7'b0001111;
    localparam seg7_t GLYPH_8     = 7'b0000000;
    localparam seg7_t GLYPH_9     = 7'b0000100;
    localparam seg7_t GLYPH_A     = 7'b0001000;
    localparam seg7_t GLYPH_B     = 7'b1100000;
    localparam seg7_t GLYPH_C     = 7'b0110001;
    localparam seg7_t GLYPH_D     = 7'b1000010;
    localparam seg7_t GLYPH_E     = 7'b0110000;
    localparam seg7_t GLYPH_F     = 7'b0111000;
    localparam seg7_t GLYPH_DASH  = 7'b1111110;
    localparam seg7_t GLYPH_BLANK = 7'b1111111;

    localparam logic [7:0] SEG8_DARK = 8'hFF;

    function automatic logic [7:0] seg8(input seg7_t g, input logic dp);
        seg_bits_t s;
        s = {g, 1'b1};
        s.dp = ~dp;
        return s;
    endfunction

endpackage

// File: rtl/ssd_glyph_decode.sv
// Nibble to seven-segment glyph, active-low.
// Values above 9 show hex letters or a dash when hex is disabled.
module ssd_glyph_decode
    import ssd_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       hex_en,
    output seg7_t      seg
);

    always_comb begin
        seg = GLYPH_BLANK;
        unique case (nibble)
            4'h0: seg = GLYPH_0;
            4'h1: seg = GLYPH_1;
            4'h2: seg = GLYPH_2;
            4'h3: seg = GLYPH_3;
            4'h4: seg = GLYPH_4;
            4'h5: seg = GLYPH_5;
            4'h6: seg = GLYPH_6;
            4'h7: seg = GLYPH_7;
            4'h8: seg = GLYPH_8;
            4'h9: seg = GLYPH_9;
            4'hA: seg = hex_en ? GLYPH_A : GLYPH_DASH;
            4'hB: seg = hex_en ? GLYPH_B : GLYPH_DASH;
            4'hC: seg = hex_en ? GLYPH_C : GLYPH_DASH;
            4'hD: seg = hex_en ? GLYPH_D : GLYPH_DASH;
            4'hE: seg = hex_en ? GLYPH_E : GLYPH_DASH;
            4'hF: seg = hex_en ? GLYPH_F : GLYPH_DASH;
        endcase
    end

endmodule

// File: rtl/ssd_scan_mux.sv
// Multiplexed common-anode display driver with a frame-aligned shadow
// copy, per-digit blanking, leading-zero suppression and anode guard.
module ssd_scan_mux
    import ssd_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int DIV_BITS = 16,
    parameter int GUARD    = 4,
    parameter int HEX_EN   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   digits_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     blank_in,
    input  logic                  load,
    input  logic                  lz_blank,
    output logic [7:0]            ssd_seg,
    output logic [DIGITS-1:0]     ssd_an,
    output logic                  frame_done
);

    localparam int   IDX_W = $clog2(DIGITS);
    localparam logic HEX   = (HEX_EN != 0);

    logic [DIV_BITS-1:0] prescaler;
    logic [IDX_W-1:0]    idx;
    logic                pending;
    logic [4*DIGITS-1:0] sh_dig;
    logic [DIGITS-1:0]   sh_dp;
    logic [DIGITS-1:0]   sh_blank;

    logic tick;
    logic last;
    logic wrap;

    assign tick = &prescaler;
    assign last = (idx == IDX_W'(DIGITS - 1));
    assign wrap = tick & last;

    // Scan timing and frame-aligned shadow capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler  <= '0;
            idx        <= '0;
            pending    <= 1'b0;
            sh_dig     <= '0;
            sh_dp      <= '0;
            sh_blank   <= '1;
            frame_done <= 1'b0;
        end else begin
            prescaler  <= prescaler + DIV_BITS'(1);
            frame_done <= wrap;
            if (tick) begin
                idx <= last ? '0 : idx + IDX_W'(1);
            end
            if (wrap) begin
                pending <= 1'b0;
                if (pending | load) begin
                    sh_dig   <= digits_in;
                    sh_dp    <= dp_in;
                    sh_blank <= blank_in;
                end
            end else if (load) begin
                pending <= 1'b1;
            end
        end
    end

    logic [3:0]        cur_nib;
    logic              cur_dp;
    logic              cur_blank;
    logic              cur_zero;
    logic [DIGITS-1:0] zero_from;

    // zero_from[i]: nibble i and every more significant nibble are 0.
    always_comb begin
        zero_from = '0;
        for (int i = 0; i < DIGITS; i++) begin
            zero_from[i] = ((sh_dig >> (4 * i)) == '0);
        end
    end

    always_comb begin
        cur_nib   = '0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        cur_zero  = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                cur_nib   = sh_dig[4*i +: 4];
                cur_dp    = sh_dp[i];
                cur_blank = sh_blank[i];
                cur_zero  = zero_from[i];
            end
        end
    end

    seg7_t glyph;

    ssd_glyph_decode u_decode (
        .nibble (cur_nib),
        .hex_en (HEX),
        .seg    (glyph)
    );

    logic              in_guard;
    logic              dark;
    logic [7:0]        seg_nxt;
    logic [DIGITS-1:0] an_nxt;

    assign in_guard = (prescaler < DIV_BITS'(GUARD));
    assign dark     = cur_blank
                    | (lz_blank & (idx != '0) & cur_zero);

    always_comb begin
        seg_nxt = SEG8_DARK;
        an_nxt  = '1;
        if (!in_guard) begin
            an_nxt  = ~(DIGITS'(1) << idx);
            seg_nxt = dark ? SEG8_DARK : seg8(glyph, cur_dp);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ssd_seg <= SEG8_DARK;
            ssd_an  <= '1;
        end else begin
            ssd_seg <= seg_nxt;
            ssd_an  <= an_nxt;
        end
    end

endmodule

// File: tb/tb_ssd_scan_mux.sv
// Scoreboard bench for ssd_scan_mux: 4 digits, 4-cycle slots, 1-cycle guard.
// A hex and a dash-decoding instance share all inputs.
module tb_ssd_scan_mux;

    localparam int DIGITS   = 4;
    localparam int DIV_BITS = 2;
    localparam int GUARD    = 1;

    logic        clk;
    logic        rst_n;
    logic [15:0] digits_in;
    logic [3:0]  dp_in;
    logic [3:0]  blank_in;
    logic        load;
    logic        lz_blank;
    logic [7:0]  ssd_seg;
    logic [3:0]  ssd_an;
    logic        frame_done;
    logic [7:0]  seg_nh;
    logic [3:0]  an_nh;
    logic        fd_nh;

    int n_cmp = 0;
    int n_bad = 0;

    ssd_scan_mux #(
        .DIGITS(DIGITS), .DIV_BITS(DIV_BITS), .GUARD(GUARD), .HEX_EN(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .digits_in(digits_in), .dp_in(dp_in),
        .blank_in(blank_in), .load(load), .lz_blank(lz_blank),
        .ssd_seg(ssd_seg), .ssd_an(ssd_an), .frame_done(frame_done)
    );

    ssd_scan_mux #(
        .DIGITS(DIGITS), .DIV_BITS(DIV_BITS), .GUARD(GUARD), .HEX_EN(0)
    ) dut_nh (
        .clk(clk), .rst_n(rst_n), .digits_in(digits_in), .dp_in(dp_in),
        .blank_in(blank_in), .load(load), .lz_blank(lz_blank),
        .ssd_seg(seg_nh), .ssd_an(an_nh), .frame_done(fd_nh)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] seg;
        logic [3:0] an;
        logic       fd;
        logic [7:0] seg_nh;
    } exp_t;

    exp_t sb[$];

    logic [1:0]  m_pre;
    logic [1:0]  m_idx;
    logic [15:0] m_dig;
    logic [3:0]  m_dp;
    logic [3:0]  m_blank;
    logic        m_pend;

    function automatic logic [7:0] glyph(input logic [3:0] n, input bit hex);
        case (n)
            4'h0: return 8'h03;
            4'h1: return 8'h9F;
            4'h2: return 8'h25;
            4'h3: return 8'h0D;
            4'h4: return 8'h99;
            4'h5: return 8'h49;
            4'h6: return 8'h41;
            4'h7: return 8'h1F;
            4'h8: return 8'h01;
            4'h9: return 8'h09;
            4'hA: return hex ? 8'h11 : 8'hFD;
            4'hB: return hex ? 8'hC1 : 8'hFD;
            4'hC: return hex ? 8'h63 : 8'hFD;
            4'hD: return hex ? 8'h85 : 8'hFD;
            4'hE: return hex ? 8'h61 : 8'hFD;
            default: return hex ? 8'h71 : 8'hFD;
        endcase
    endfunction

    function automatic exp_t predict();
        exp_t       e;
        logic [3:0] n;
        logic [7:0] dpm;
        bit         dk;
        e.fd = (m_pre == 2'd3) && (m_idx == 2'd3);
        if (m_pre < GUARD) begin
            e.seg    = 8'hFF;
            e.an     = 4'hF;
            e.seg_nh = 8'hFF;
        end else begin
            e.an        = 4'hF;
            e.an[m_idx] = 1'b0;
            n   = m_dig[m_idx*4 +: 4];
            dpm = m_dp[m_idx] ? 8'hFE : 8'hFF;
            dk  = m_blank[m_idx]
               || (lz_blank && m_idx != 0 && (m_dig >> (m_idx*4)) == 16'h0);
            e.seg    = dk ? 8'hFF : (glyph(n, 1) & dpm);
            e.seg_nh = dk ? 8'hFF : (glyph(n, 0) & dpm);
        end
        return e;
    endfunction

    // Reference model: one expected output word per active clock edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pre   <= 2'd0;
            m_idx   <= 2'd0;
            m_dig   <= 16'h0;
            m_dp    <= 4'h0;
            m_blank <= 4'hF;
            m_pend  <= 1'b0;
        end else begin
            sb.push_back(predict());
            m_pre <= m_pre + 2'd1;
            if (m_pre == 2'd3) m_idx <= m_idx + 2'd1;
            if (m_pre == 2'd3 && m_idx == 2'd3) begin
                m_pend <= 1'b0;
                if (m_pend || load) begin
                    m_dig   <= digits_in;
                    m_dp    <= dp_in;
                    m_blank <= blank_in;
                end
            end else if (load) begin
                m_pend <= 1'b1;
            end
        end
    end

    task automatic test_reset();
        exp_t e;
        logic [3:0] m;
        rst_n = 1'b0; load = 1'b0; lz_blank = 1'b0;
        digits_in = 16'h0; dp_in = 4'h0; blank_in = 4'h0;
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({ssd_seg, ssd_an, frame_done} !== {8'hFF, 4'hF, 1'b0}) begin
            n_bad++;
            $display("FAIL reset_state: seg=%h an=%b fd=%b, want FF 1111 0",
                     ssd_seg, ssd_an, frame_done);
        end
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL reset_sb: no expected entry");
            end else begin
                e = sb.pop_front();
                if ({ssd_seg, ssd_an, frame_done, seg_nh, an_nh, fd_nh} !==
                    {e.seg, e.an, e.fd, e.seg_nh, e.an, e.fd}) begin
                    n_bad++;
                    $display("FAIL reset_sb: seg=%h an=%b fd=%b nh=%h, want %h %b %b %h",
                             ssd_seg, ssd_an, frame_done, seg_nh,
                             e.seg, e.an, e.fd, e.seg_nh);
                end
            end
            for (int k = 0; k < 4; k++) begin
                m = 4'b1 << k;
                if (ssd_an == ~m) begin
                    n_cmp++;
                    if (ssd_seg !== 8'hFF) begin
                        n_bad++;
                        $display("FAIL reset_dark%0d: seg=%h want FF", k, ssd_seg);
                    end
                end
            end
        end
    endtask

    task automatic test_load();
        exp_t e;
        logic [3:0] m;
        logic [7:0] lit[4];
        bit live;
        lit  = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
        live = 0;
        digits_in = 16'h1234; dp_in = 4'h0; blank_in = 4'h0; load = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            n_cmp++;
            e = '0;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL load_sb: no expected entry");
            end else begin
                e = sb.pop_front();
                if ({ssd_seg, ssd_an, frame_done, seg_nh, an_nh, fd_nh} !==
                    {e.seg, e.an, e.fd, e.seg_nh, e.an, e.fd}) begin
                    n_bad++;
                    $display("FAIL load_sb: seg=%h an=%b fd=%b nh=%h, want %h %b %b %h",
                             ssd_seg, ssd_an, frame_done, seg_nh,
                             e.seg, e.an, e.fd, e.seg_nh);
                end
            end
            for (int k = 0; k < 4; k++) begin
                m = 4'b1 << k;
                if (ssd_an == ~m) begin
                    n_cmp++;
                    if (ssd_seg !== lit[k]) begin
                        n_bad++;
                        $display("FAIL load_digit%0d: seg=%h want %h", k, ssd_seg, lit[k]);
                    end
                end
            end
            if (!live && e.fd) begin
                live = 1;
                lit  = '{8'h99, 8'h0D, 8'h25, 8'h9F};
            end
            load = 1'b0;
        end
        n_cmp++;
        if (!live) begin
            n_bad++;
            $display("FAIL load_capture: no frame wrap seen, want one");
        end
    endtask

    task automatic test_hex_lz();
        exp_t e;
        logic [3:0] m;
        logic [7:0] lit[4];
        logic [7:0] lnh[4];
        bit live;
        lit  = '{8'h99, 8'h0D, 8'h25, 8'h9F};
        lnh  = lit;
        live = 0;
        lz_blank = 1'b1;
        digits_in = 16'h00A0; load = 1'b1;
        for (int c = 0; c < 36; c++) begin
            @(negedge clk);
            n_cmp++;
            e = '0;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL hex_sb: no expected entry");
            end else begin
                e = sb.pop_front();
                if ({ssd_seg, ssd_an, frame_done, seg_nh, an_nh, fd_nh} !==
                    {e.seg, e.an, e.fd, e.seg_nh, e.an, e.fd}) begin
                    n_bad++;
                    $display("FAIL hex_sb: seg=%h an=%b fd=%b nh=%h, want %h %b %b %h",
                             ssd_seg, ssd_an, frame_done, seg_nh,
                             e.seg, e.an, e.fd, e.seg_nh);
                end
            end
            for (int k = 0; k < 4; k++) begin
                m = 4'b1 << k;
                if (ssd_an == ~m) begin
                    n_cmp++;
                    if (ssd_seg !== lit[k] || seg_nh !== lnh[k]) begin
                        n_bad++;
                        $display("FAIL hex_digit%0d: seg=%h nh=%h want %h %h",
                                 k, ssd_seg, seg_nh, lit[k], lnh[k]);
                    end
                end
            end
            if (!live && e.fd) begin
                live = 1;
                lit  = '{8'h03, 8'h11, 8'hFF, 8'hFF};
                lnh  = '{8'h03, 8'hFD, 8'hFF, 8'hFF};
            end
            load = 1'b0;
        end
    endtask

    task automatic test_zero_dp();
        exp_t e;
        logic [3:0] m;
        logic [7:0] lit[4];
        bit live;
        bit lz_off;
        int since;
        lit    = '{8'h03, 8'h11, 8'hFF, 8'hFF};
        live   = 0;
        lz_off = 0;
        since  = 0;
        digits_in = 16'h0000; dp_in = 4'b0100; load = 1'b1;
        for (int c = 0; c < 48; c++) begin
            @(negedge clk);
            n_cmp++;
            e = '0;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL zero_sb: no expected entry");
            end else begin
                e = sb.pop_front();
                if ({ssd_seg, ssd_an, frame_done, seg_nh, an_nh, fd_nh} !==
                    {e.seg, e.an, e.fd, e.seg_nh, e.an, e.fd}) begin
                    n_bad++;
                    $display("FAIL zero_sb: seg=%h an=%b fd=%b nh=%h, want %h %b %b %h",
                             ssd_seg, ssd_an, frame_done, seg_nh,
                             e.seg, e.an, e.fd, e.seg_nh);
                end
            end
            for (int k = 0; k < 4; k++) begin
                m = 4'b1 << k;
                if (ssd_an == ~m) begin
                    n_cmp++;
                    if (ssd_seg !== lit[k]) begin
                        n_bad++;
                        $display("FAIL zero_digit%0d: seg=%h want %h lz=%b",
                                 k, ssd_seg, lit[k], lz_blank);
                    end
                end
            end
            if (!live && e.fd) begin
                live = 1;
                lit  = '{8'h03, 8'hFF, 8'hFF, 8'hFF};
            end else if (live && !lz_off) begin
                since++;
                if (since == 18) begin
                    lz_off   = 1;
                    lz_blank = 1'b0;
                    lit      = '{8'h03, 8'h03, 8'h02, 8'h03};
                end
            end
            load = 1'b0;
        end
    endtask

    task automatic test_midframe();
        exp_t e;
        logic [3:0] m;
        logic [7:0] lit[4];
        bit started;
        bit live;
        int s;
        int fds;
        lit     = '{8'h03, 8'h03, 8'h02, 8'h03};
        started = 0;
        live    = 0;
        s       = 0;
        fds     = 0;
        for (int c = 0; c < 70; c++) begin
            @(negedge clk);
            n_cmp++;
            e = '0;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL mid_sb: no expected entry");
            end else begin
                e = sb.pop_front();
                if ({ssd_seg, ssd_an, frame_done, seg_nh, an_nh, fd_nh} !==
                    {e.seg, e.an, e.fd, e.seg_nh, e.an, e.fd}) begin
                    n_bad++;
                    $display("FAIL mid_sb: seg=%h an=%b fd=%b nh=%h, want %h %b %b %h",
                             ssd_seg, ssd_an, frame_done, seg_nh,
                             e.seg, e.an, e.fd, e.seg_nh);
                end
            end
            for (int k = 0; k < 4; k++) begin
                m = 4'b1 << k;
                if (ssd_an == ~m) begin
                    n_cmp++;
                    if (ssd_seg !== lit[k]) begin
                        n_bad++;
                        $display("FAIL mid_digit%0d: seg=%h want %h", k, ssd_seg, lit[k]);
                    end
                end
            end
            if (started && c > s && c <= s + 48 && frame_done === 1'b1) fds++;
            if (started && !live && e.fd) begin
                live = 1;
                lit  = '{8'h01, 8'h1F, 8'h41, 8'h49};
            end
            load = 1'b0;
            if (!started && m_idx == 2'd1 && m_pre == 2'd1) begin
                started   = 1;
                s         = c;
                digits_in = 16'h9999; dp_in = 4'h0; load = 1'b1;
            end else if (started && c == s + 5) begin
                digits_in = 16'h5678; load = 1'b1;
            end
        end
        n_cmp++;
        if (!started || fds != 3) begin
            n_bad++;
            $display("FAIL mid_frame_done: pulses=%0d in 48 clk want 3 (started=%0d)",
                     fds, started);
        end
    endtask

    task automatic test_wrap_onehot();
        exp_t e;
        logic [3:0] m;
        logic [7:0] lit[4];
        bit armed;
        bit live;
        lit   = '{8'h01, 8'h1F, 8'h41, 8'h49};
        armed = 0;
        live  = 0;
        for (int c = 0; c < 170; c++) begin
            @(negedge clk);
            n_cmp++;
            e = '0;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL wrap_sb: no expected entry");
            end else begin
                e = sb.pop_front();
                if ({ssd_seg, ssd_an, frame_done, seg_nh, an_nh, fd_nh} !==
                    {e.seg, e.an, e.fd, e.seg_nh, e.an, e.fd}) begin
                    n_bad++;
                    $display("FAIL wrap_sb: seg=%h an=%b fd=%b nh=%h, want %h %b %b %h",
                             ssd_seg, ssd_an, frame_done, seg_nh,
                             e.seg, e.an, e.fd, e.seg_nh);
                end
            end
            n_cmp++;
            if ($countones(~ssd_an) > 1) begin
                n_bad++;
                $display("FAIL onehot: an=%b want at most one low", ssd_an);
            end
            for (int k = 0; k < 4; k++) begin
                m = 4'b1 << k;
                if (ssd_an == ~m) begin
                    n_cmp++;
                    if (ssd_seg !== lit[k]) begin
                        n_bad++;
                        $display("FAIL wrap_digit%0d: seg=%h want %h", k, ssd_seg, lit[k]);
                    end
                end
            end
            if (armed && !live && e.fd) begin
                live = 1;
                lit  = '{8'h63, 8'hC1, 8'h11, 8'h09};
            end
            if (load) digits_in = 16'h1111;
            load = 1'b0;
            if (!armed && c > 4 && m_pre == 2'd3 && m_idx == 2'd3) begin
                armed     = 1;
                digits_in = 16'h9ABC; dp_in = 4'h0; blank_in = 4'h0;
                load      = 1'b1;
            end
        end
        n_cmp++;
        if (!armed || !live) begin
            n_bad++;
            $display("FAIL wrap_capture: armed=%0d live=%0d want 1 1", armed, live);
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        logic [3:0] m;
        bit found;
        found = 0;
        for (int c = 0; c < 8 && !found; c++) begin
            @(negedge clk);
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL rmid_sb: no expected entry");
            end else begin
                e = sb.pop_front();
                if ({ssd_seg, ssd_an, frame_done} !== {e.seg, e.an, e.fd}) begin
                    n_bad++;
                    $display("FAIL rmid_sb: seg=%h an=%b fd=%b, want %h %b %b",
                             ssd_seg, ssd_an, frame_done, e.seg, e.an, e.fd);
                end
            end
            if (m_pre == 2'd2) found = 1;
        end
        n_cmp++;
        if (!found) begin
            n_bad++;
            $display("FAIL rmid_align: mid-slot point not reached");
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({ssd_seg, ssd_an, frame_done, seg_nh, an_nh} !==
            {8'hFF, 4'hF, 1'b0, 8'hFF, 4'hF}) begin
            n_bad++;
            $display("FAIL rmid_async: seg=%h an=%b fd=%b nh=%h, want FF 1111 0 FF",
                     ssd_seg, ssd_an, frame_done, seg_nh);
        end
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL rmid_post: no expected entry");
            end else begin
                e = sb.pop_front();
                if ({ssd_seg, ssd_an, frame_done, seg_nh, an_nh, fd_nh} !==
                    {e.seg, e.an, e.fd, e.seg_nh, e.an, e.fd}) begin
                    n_bad++;
                    $display("FAIL rmid_post: seg=%h an=%b fd=%b nh=%h, want %h %b %b %h",
                             ssd_seg, ssd_an, frame_done, seg_nh,
                             e.seg, e.an, e.fd, e.seg_nh);
                end
            end
            for (int k = 0; k < 4; k++) begin
                m = 4'b1 << k;
                if (ssd_an == ~m) begin
                    n_cmp++;
                    if (ssd_seg !== 8'hFF) begin
                        n_bad++;
                        $display("FAIL rmid_dark%0d: seg=%h want FF", k, ssd_seg);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_hex_lz();
        test_zero_dp();
        test_midframe();
        test_wrap_onehot();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
